alu_exec: RTL and testbench

Execute-stage ALU, directly downstream of ALU_control: it consumes the 3-bit ALU control code and two register operands and produces a registered result plus a zero flag for branch resolution. Add/sub/AND/OR finish in one cycle. Signed divide, and multiply when built iterative, run as multi-cycle operations behind a ready/valid handshake that the pipeline uses to stall.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_divider.sv | 59 +++++
 rtl/alu_exec.sv | 161 ++++++++++++++++
 tb/tb_alu_exec.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes common with ALU_control and the
// execute-stage FSM state encoding.
package alu_pkg;

  localparam logic [2:0] ALU_NOP = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_MUL = 3'b011;
  localparam logic [2:0] ALU_DIV = 3'b100;
  localparam logic [2:0] ALU_AND = 3'b101;
  localparam logic [2:0] ALU_OR  = 3'b110;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIV     = 2'd1,
    DIV_FIX = 2'd2,
    MUL     = 2'd3
  } alu_state_e;

endpackage

// File: rtl/alu_divider.sv
// Restoring unsigned divider: one quotient bit per cycle over WIDTH
// cycles. Operands are magnitudes; sign handling lives in alu_exec.
module alu_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient
);

  localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(WIDTH - 1);

  logic             r_busy;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic             w_ge;

  // Trial subtraction of the divisor from the shifted partial remainder.
  always_comb begin
    w_shift = {r_rem, r_quo[WIDTH-1]};
    w_trial = w_shift - {1'b0, r_dvs};
    w_ge    = ~w_trial[WIDTH];
  end

  // Done is asserted during the cycle whose closing edge performs the last iteration.
  assign o_done     = r_busy && (r_cnt == CNT_LAST);
  assign o_quotient = r_quo;

  // Iteration state: quotient shifts in from the dividend register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_rem  <= '0;
      r_quo  <= '0;
      r_dvs  <= '0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_cnt  <= '0;
      r_rem  <= '0;
      r_quo  <= i_dividend;
      r_dvs  <= i_divisor;
    end else if (r_busy) begin
      r_rem <= w_ge ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
      r_quo <= {r_quo[WIDTH-2:0], w_ge};
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == CNT_LAST) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_exec.sv
// Execute-stage ALU. Single-cycle add/sub/and/or/nop, iterative signed
// divide, and multiply that is iterative shift-add when
// ALU_EXEC_MUL_ITER_EN is defined (single-cycle product otherwise).
module alu_exec
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  alu_state_e       r_state, w_next;
  logic             w_accept;
  logic             w_load;
  logic [WIDTH-1:0] w_res_d;
  logic             w_div_start;
  logic             w_div_done;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_abs_a, w_abs_b;
  logic             r_neg;

`ifdef ALU_EXEC_MUL_ITER_EN
  localparam logic [WIDTH-1:0] MCNT_LAST = WIDTH'(WIDTH - 1);
  logic             w_mul_start;
  logic [WIDTH-1:0] r_mcand, r_mplier, r_acc, r_mcnt;
  logic [WIDTH-1:0] w_addend;
  assign w_addend = r_mplier[0] ? r_mcand : '0;
`else
  logic [WIDTH-1:0] w_prod;
  assign w_prod = op_a * op_b;
`endif

  assign in_ready = (r_state == IDLE);
  assign w_accept = in_valid && in_ready;
  assign w_abs_a  = op_a[WIDTH-1] ? -op_a : op_a;
  assign w_abs_b  = op_b[WIDTH-1] ? -op_b : op_b;

  alu_divider #(.WIDTH(WIDTH)) u_div (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_div_start),
    .i_dividend (w_abs_a),
    .i_divisor  (w_abs_b),
    .o_done     (w_div_done),
    .o_quotient (w_quo)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next state, result-load strobe and result value.
  always_comb begin
    w_next      = r_state;
    w_load      = 1'b0;
    w_res_d     = '0;
    w_div_start = 1'b0;
`ifdef ALU_EXEC_MUL_ITER_EN
    w_mul_start = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          case (alu_ctrl)
            ALU_ADD: begin w_load = 1'b1; w_res_d = op_a + op_b; end
            ALU_SUB: begin w_load = 1'b1; w_res_d = op_a - op_b; end
            ALU_AND: begin w_load = 1'b1; w_res_d = op_a & op_b; end
            ALU_OR:  begin w_load = 1'b1; w_res_d = op_a | op_b; end
`ifdef ALU_EXEC_MUL_ITER_EN
            ALU_MUL: begin w_mul_start = 1'b1; w_next = MUL; end
`else
            ALU_MUL: begin w_load = 1'b1; w_res_d = w_prod; end
`endif
            ALU_DIV: begin
              // Divide by zero bypasses the divider with the all-ones quotient.
              if (op_b == '0) begin
                w_load  = 1'b1;
                w_res_d = '1;
              end else begin
                w_div_start = 1'b1;
                w_next      = DIV;
              end
            end
            default: begin w_load = 1'b1; w_res_d = '0; end
          endcase
        end
      end
      DIV: if (w_div_done) w_next = DIV_FIX;
      DIV_FIX: begin
        w_load  = 1'b1;
        w_res_d = r_neg ? -w_quo : w_quo;
        w_next  = IDLE;
      end
`ifdef ALU_EXEC_MUL_ITER_EN
      MUL: begin
        if (r_mcnt == MCNT_LAST) begin
          w_load  = 1'b1;
          w_res_d = r_acc + w_addend;
          w_next  = IDLE;
        end
      end
`endif
      default: w_next = IDLE;
    endcase
  end

  // Quotient sign, captured when the divide starts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              r_neg <= 1'b0;
    else if (w_div_start) r_neg <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
  end

`ifdef ALU_EXEC_MUL_ITER_EN
  // Shift-add multiplier: multiplicand shifts left, multiplier shifts right.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_mcnt   <= '0;
    end else if (w_mul_start) begin
      r_mcand  <= op_a;
      r_mplier <= op_b;
      r_acc    <= '0;
      r_mcnt   <= '0;
    end else if (r_state == MUL) begin
      r_acc    <= r_acc + w_addend;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_mcnt   <= r_mcnt + 1'b1;
    end
  end
`endif

  // Output registers: result/zero hold until the next completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
    end else begin
      out_valid <= w_load;
      if (w_load) begin
        result <= w_res_d;
        zero   <= (w_res_d == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
module tb_alu_exec;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [2:0]   alu_ctrl;
  logic [W-1:0] op_a, op_b;
  logic         in_ready, out_valid, zero;
  logic [W-1:0] result;

  int n_chk = 0;
  int n_fail = 0;
  logic [W-1:0] prev_res;
  logic         prev_zero;

  alu_exec #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .alu_ctrl(alu_ctrl),
    .op_a(op_a), .op_b(op_b), .in_ready(in_ready), .out_valid(out_valid),
    .result(result), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain arithmetic straight from the op-code definitions.
  function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] p;
    case (op)
      3'b001: return a + b;
      3'b010: return a - b;
      3'b011: begin p = 64'(a) * 64'(b); return p[W-1:0]; end
      3'b100: begin
        if (b == 0) return '1;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return W'($signed(a) / $signed(b));
      end
      3'b101: return a & b;
      3'b110: return a | b;
      default: return '0;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] op, input logic [W-1:0] b);
    if (op == 3'b100 && b != 0) return W + 2;
`ifdef ALU_EXEC_MUL_ITER_EN
    if (op == 3'b011) return W + 1;
`endif
    return 1;
  endfunction

  // Called at a negedge; returns at the negedge of the out_valid cycle.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] e;
    int n;
    e = model(op, a, b);
    in_valid = 1'b1; alu_ctrl = op; op_a = a; op_b = b;
    @(posedge clk); #1;
    in_valid = 1'b0; alu_ctrl = 3'($urandom); op_a = $urandom; op_b = $urandom;
    n = 1;
    @(negedge clk);
    while (!out_valid && n < 200) begin
      chk({tag, "_busy_rdy"}, 64'(in_ready), 64'(0));
      chk({tag, "_hold"}, 64'({zero, result}), 64'({prev_zero, prev_res}));
      in_valid = 1'($urandom_range(0, 1));
      alu_ctrl = 3'($urandom); op_a = $urandom; op_b = $urandom;
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    chk({tag, "_lat"}, 64'(n), 64'(exp_lat(op, b)));
    chk({tag, "_res"}, 64'(result), 64'(e));
    chk({tag, "_zero"}, 64'(zero), 64'(e == 0));
    chk({tag, "_rdy"}, 64'(in_ready), 64'(1));
    prev_res = e; prev_zero = (e == 0);
  endtask

  logic [2:0]   bo [5];
  logic [W-1:0] ba [5];
  logic [W-1:0] bb [5];

  initial begin
    int cnt;
    logic [2:0] op;
    logic [W-1:0] a, b;
    rst = 1'b1; in_valid = 1'b0; alu_ctrl = '0; op_a = '0; op_b = '0;
    repeat (2) @(negedge clk);
    chk("rst_res", 64'(result), 64'(0));
    chk("rst_zero", 64'(zero), 64'(0));
    chk("rst_ov", 64'(out_valid), 64'(0));
    chk("rst_rdy", 64'(in_ready), 64'(1));
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back single-cycle ops, one result per cycle.
    bo = '{3'b001, 3'b010, 3'b101, 3'b110, 3'b010};
    ba = '{32'd5, 32'd5, 32'hF0F0, 32'h1, 32'd0};
    bb = '{32'd7, 32'd5, 32'h0FF0, 32'h2, 32'd1};
    for (int i = 0; i <= 5; i++) begin
      if (i > 0) begin
        chk($sformatf("b2b%0d_ov", i-1), 64'(out_valid), 64'(1));
        chk($sformatf("b2b%0d_res", i-1), 64'(result), 64'(model(bo[i-1], ba[i-1], bb[i-1])));
        chk($sformatf("b2b%0d_zero", i-1), 64'(zero), 64'(model(bo[i-1], ba[i-1], bb[i-1]) == 0));
        chk($sformatf("b2b%0d_rdy", i-1), 64'(in_ready), 64'(1));
      end
      if (i < 5) begin
        in_valid = 1'b1; alu_ctrl = bo[i]; op_a = ba[i]; op_b = bb[i];
      end else in_valid = 1'b0;
      @(posedge clk); @(negedge clk);
    end
    prev_res = 32'hFFFF_FFFF; prev_zero = 1'b0;
    chk("b2b_ov_pulse", 64'(out_valid), 64'(0));

    // Reset in the middle of a divide discards it.
    in_valid = 1'b1; alu_ctrl = 3'b100; op_a = 32'd100; op_b = 32'd7;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mrst_res", 64'(result), 64'(0));
    chk("mrst_zero", 64'(zero), 64'(0));
    chk("mrst_ov", 64'(out_valid), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_rdy", 64'(in_ready), 64'(1));
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    chk("mrst_no_ov", 64'(cnt), 64'(0));
    prev_res = '0; prev_zero = 1'b0;

    // Directed divide/multiply/nop cases.
    run_op("div_m7_2", 3'b100, -32'sd7, 32'd2);
    run_op("div_7_m2", 3'b100, 32'd7, -32'sd2);
    run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
    // Same-edge accept right at the div out_valid cycle.
    run_op("after_div_add", 3'b001, 32'd1, 32'd2);
    run_op("div_by0", 3'b100, 32'd20, 32'd0);
    run_op("div_100_7", 3'b100, 32'd100, 32'd7);
    run_op("mul_6_7", 3'b011, 32'd6, 32'd7);
    run_op("mul_m1_3", 3'b011, 32'hFFFF_FFFF, 32'd3);
    run_op("nop", 3'b000, 32'd9, 32'd9);
    run_op("op111", 3'b111, 32'd3, 32'd4);

    // Randomized ops with edge-biased operands.
    for (int i = 0; i < 80; i++) begin
      op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: a = 32'h8000_0000;
        1: a = 32'($urandom_range(0, 20)) - 32'd10;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0: b = '0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'($urandom_range(0, 20)) - 32'd10;
        default: b = $urandom;
      endcase
      run_op($sformatf("rnd%0d", i), op, a, b);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
